// File: rtl/b_pc_ras.sv
// b_pc_ras: next-PC generator for the single-cycle core. It includes a
// circular return-address stack (RAS) for call/return.
//
// Next-PC priority, highest first:
//   reset > stall > ret > call > jump > branch > sequential (pc+4)
//
// Parameters:
//   WIDTH     - PC / address width in bits
//   OP_W      - opcode width; the jump immediate is WIDTH-OP_W bits
//   IMM_W     - branch word-offset width (signed)
//   RAS_DEPTH - number of RAS entries (power of two, >= 2)
//   RESET_VEC - PC loaded on reset (word aligned)
//
// Ports:
//   clk, reset          - clock; synchronous active-high reset
//   stall               - hold PC, RAS and flags; all strobes are ignored
//   jump/call/ret/branch- control strobes from decode
//   jimm                - jump/call target field
//   bimm                - signed branch word offset
//   pc                  - registered current PC
//   pc_plus4            - pc + 4 (combinational)
//   ras_empty/ras_full  - RAS occupancy (combinational)
//   ras_ovf/ras_unf     - sticky overflow/underflow; cleared only by reset
//   ras_count           - live entry count; present only when the macro
//                         PC_RAS_DEPTH_OUT_EN is defined
module b_pc_ras #(
    parameter int              WIDTH     = 32,
    parameter int              OP_W      = 6,
    parameter int              IMM_W     = 16,
    parameter int              RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 stall,
    input  logic                                 jump,
    input  logic                                 call,
    input  logic                                 ret,
    input  logic                                 branch,
    input  logic [WIDTH-OP_W-1:0]                jimm,
    input  logic signed [IMM_W-1:0]              bimm,
    output logic [WIDTH-1:0]                     pc,
    output logic [WIDTH-1:0]                     pc_plus4,
    output logic                                 ras_empty,
    output logic                                 ras_full,
    output logic                                 ras_ovf,
`ifdef PC_RAS_DEPTH_OUT_EN
    output logic                                 ras_unf,
    output logic [$clog2(RAS_DEPTH+1)-1:0]       ras_count
`else
    output logic                                 ras_unf
`endif
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    // Sign-extend the word offset, scale it to bytes and add it to the base.
    function automatic logic [WIDTH-1:0] branch_target(
        input logic [WIDTH-1:0]        base,
        input logic signed [IMM_W-1:0] off
    );
        logic [WIDTH-1:0] off_ext;
        off_ext = {{(WIDTH-IMM_W){off[IMM_W-1]}}, off};
        return base + (off_ext << 2);
    endfunction

    // The target keeps the upper bits of pc+4 (pseudo-direct addressing).
    function automatic logic [WIDTH-1:0] jump_target(
        input logic [WIDTH-1:0]      base,
        input logic [WIDTH-OP_W-1:0] imm
    );
        return {base[WIDTH-1:WIDTH-OP_W+2], imm, 2'b00};
    endfunction

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic             wr_en;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] top_inc;
    logic [PTR_W-1:0] top_dec;
    logic             empty;
    logic             full;

    assign pc_plus4 = pc_q + WIDTH'(4);
    // RAS_DEPTH is a power of two, so the pointer wraps naturally.
    assign top_inc  = top_q + PTR_W'(1);
    assign top_dec  = top_q - PTR_W'(1);
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_FULL);

    always_comb begin
        pc_d   = pc_q;
        top_d  = top_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        wr_en  = 1'b0;
        wr_ptr = top_q;
        if (!stall) begin
            if (ret && call) begin
                if (empty) begin
                    // An underflowed swap falls through to pc+4 and still pushes.
                    pc_d   = pc_plus4;
                    unf_d  = 1'b1;
                    wr_en  = 1'b1;
                    wr_ptr = top_inc;
                    top_d  = top_inc;
                    cnt_d  = cnt_q + CNT_W'(1);
                end else begin
                    // Replace the top entry in place: the pop and the push cancel.
                    pc_d   = ras_q[top_q];
                    wr_en  = 1'b1;
                    wr_ptr = top_q;
                end
            end else if (ret) begin
                if (empty) begin
                    pc_d  = pc_plus4;
                    unf_d = 1'b1;
                end else begin
                    pc_d  = ras_q[top_q];
                    top_d = top_dec;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else if (call) begin
                // When the RAS is full, the push overwrites the oldest entry.
                pc_d   = jump_target(pc_plus4, jimm);
                wr_en  = 1'b1;
                wr_ptr = top_inc;
                top_d  = top_inc;
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (jump) begin
                pc_d = jump_target(pc_plus4, jimm);
            end else if (branch) begin
                pc_d = branch_target(pc_plus4, bimm);
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_VEC;
            top_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // The entry contents need no reset; the count marks which entries are valid.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            ras_q[wr_ptr] <= pc_plus4;
        end
    end

    assign pc        = pc_q;
    assign ras_empty = empty;
    assign ras_full  = full;
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;
`ifdef PC_RAS_DEPTH_OUT_EN
    assign ras_count = cnt_q;
`endif

endmodule

// File: tb/tb_b_pc_ras.sv
// Directed testbench for b_pc_ras. The main instance uses the default
// parameters. A second instance with a high RESET_VEC shares the same
// stimulus. It covers the pseudo-direct call that keeps the upper PC bits.
module tb_b_pc_ras;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        jump;
    logic        call;
    logic        ret;
    logic        branch;
    logic [25:0] jimm;
    logic [15:0] bimm;

    logic [31:0] pc, pc_plus4;
    logic        ras_empty, ras_full, ras_ovf, ras_unf;
    logic [31:0] pc_h, pc_plus4_h;
    logic        ras_empty_h, ras_full_h, ras_ovf_h, ras_unf_h;
`ifdef PC_RAS_DEPTH_OUT_EN
    logic [2:0]  ras_count, ras_count_h;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    b_pc_ras u_dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .jump      (jump),
        .call      (call),
        .ret       (ret),
        .branch    (branch),
        .jimm      (jimm),
        .bimm      (bimm),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_ovf   (ras_ovf),
`ifdef PC_RAS_DEPTH_OUT_EN
        .ras_unf   (ras_unf),
        .ras_count (ras_count)
`else
        .ras_unf   (ras_unf)
`endif
    );

    b_pc_ras #(.RESET_VEC(32'h4000_0010)) u_dut_hi (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .jump      (jump),
        .call      (call),
        .ret       (ret),
        .branch    (branch),
        .jimm      (jimm),
        .bimm      (bimm),
        .pc        (pc_h),
        .pc_plus4  (pc_plus4_h),
        .ras_empty (ras_empty_h),
        .ras_full  (ras_full_h),
        .ras_ovf   (ras_ovf_h),
`ifdef PC_RAS_DEPTH_OUT_EN
        .ras_unf   (ras_unf_h),
        .ras_count (ras_count_h)
`else
        .ras_unf   (ras_unf_h)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle before sampling.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall  = 1'b0;
        jump   = 1'b0;
        call   = 1'b0;
        ret    = 1'b0;
        branch = 1'b0;
        jimm   = '0;
        bimm   = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #2;
        cycle();
        cycle();

        // Reset state and sequential fetch
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc4", pc_plus4, 32'h4);
        chk("rst_empty", 32'(ras_empty), 32'h1);
        chk("rst_full", 32'(ras_full), 32'h0);
        chk("rst_ovf", 32'(ras_ovf), 32'h0);
        chk("rst_unf", 32'(ras_unf), 32'h0);
        chk("rst_pc_hi", pc_h, 32'h4000_0010);
`ifdef PC_RAS_DEPTH_OUT_EN
        chk("rst_count", 32'(ras_count), 32'h0);
`endif
        reset = 1'b0;
        cycle(); chk("seq_4", pc, 32'h4);
        cycle(); chk("seq_8", pc, 32'h8);
        cycle(); chk("seq_c", pc, 32'hC);
        chk("seq_empty", 32'(ras_empty), 32'h1);

        // Branches, including jump-over-branch priority
        jump = 1'b1; jimm = 26'h40;
        cycle(); chk("jmp_100", pc, 32'h100);
        jump = 1'b0; branch = 1'b1; bimm = 16'hFFFC;
        cycle(); chk("br_neg", pc, 32'h0F4);
        jump = 1'b1; jimm = 26'h40; bimm = 16'h0003;
        cycle(); chk("jmp_over_br", pc, 32'h100);
        jump = 1'b0;
        cycle(); chk("br_pos", pc, 32'h110);
        idle();

        // Call and return with the upper PC bits preserved
        do_reset();
        call = 1'b1; jimm = 26'h40;
        cycle();
        chk("call_hi_pc", pc_h, 32'h4000_0100);
        chk("call_hi_empty", 32'(ras_empty_h), 32'h0);
        chk("call_lo_pc", pc, 32'h100);
        call = 1'b0; ret = 1'b1;
        cycle();
        chk("ret_hi_pc", pc_h, 32'h4000_0014);
        chk("ret_hi_empty", 32'(ras_empty_h), 32'h1);
        chk("ret_lo_pc", pc, 32'h4);
        idle();

        // Five nested calls on a depth-4 RAS
        do_reset();
        call = 1'b1;
        jimm = 26'h10; cycle(); chk("nest1", pc, 32'h40);
        jimm = 26'h20; cycle(); chk("nest2", pc, 32'h80);
        jimm = 26'h30; cycle(); chk("nest3", pc, 32'hC0);
        jimm = 26'h40; cycle(); chk("nest4", pc, 32'h100);
        chk("nest4_full", 32'(ras_full), 32'h1);
        chk("nest4_ovf", 32'(ras_ovf), 32'h0);
`ifdef PC_RAS_DEPTH_OUT_EN
        chk("nest4_count", 32'(ras_count), 32'h4);
`endif
        jimm = 26'h50; cycle(); chk("nest5", pc, 32'h140);
        chk("nest5_full", 32'(ras_full), 32'h1);
        chk("nest5_ovf", 32'(ras_ovf), 32'h1);
        call = 1'b0; ret = 1'b1;
        cycle(); chk("pop5", pc, 32'h104);
        cycle(); chk("pop4", pc, 32'hC4);
        cycle(); chk("pop3", pc, 32'h84);
        cycle(); chk("pop2", pc, 32'h44);
        chk("pop_empty", 32'(ras_empty), 32'h1);
        chk("pop_unf0", 32'(ras_unf), 32'h0);
        cycle(); chk("unf_pc", pc, 32'h48);
        chk("unf_flag", 32'(ras_unf), 32'h1);
        chk("ovf_sticky", 32'(ras_ovf), 32'h1);
        idle();

        // Stall holds a pending call
        do_reset();
        stall = 1'b1; call = 1'b1; jimm = 26'h10;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_pc", pc, 32'h0);
            chk("stall_empty", 32'(ras_empty), 32'h1);
        end
        stall = 1'b0;
        cycle(); chk("unstall_pc", pc, 32'h40);
        chk("unstall_empty", 32'(ras_empty), 32'h0);
        call = 1'b0; ret = 1'b1;
        cycle(); chk("unstall_ret", pc, 32'h4);
        chk("unstall_once", 32'(ras_empty), 32'h1);

        // Swap on an empty RAS underflows, then pushes pc+4
        call = 1'b1;
        cycle(); chk("swap0_pc", pc, 32'h8);
        chk("swap0_unf", 32'(ras_unf), 32'h1);
        chk("swap0_empty", 32'(ras_empty), 32'h0);
        call = 1'b0;
        cycle(); chk("swap0_pop", pc, 32'h8);
        chk("swap0_pop_empty", 32'(ras_empty), 32'h1);
        idle();

        // Swap with one entry, then reset overrides a call
        do_reset();
        jump = 1'b1; jimm = 26'h7F;
        cycle(); chk("swap_setup_jmp", pc, 32'h1FC);
        jump = 1'b0; call = 1'b1; jimm = 26'hC0;
        cycle(); chk("swap_setup_call", pc, 32'h300);
        ret = 1'b1;
        cycle(); chk("swap_pc", pc, 32'h200);
        chk("swap_empty", 32'(ras_empty), 32'h0);
        chk("swap_full", 32'(ras_full), 32'h0);
`ifdef PC_RAS_DEPTH_OUT_EN
        chk("swap_count", 32'(ras_count), 32'h1);
`endif
        call = 1'b0;
        cycle(); chk("swap_top", pc, 32'h304);
        chk("swap_pop_empty", 32'(ras_empty), 32'h1);
        cycle(); chk("swap_unf_pc", pc, 32'h308);
        chk("swap_unf", 32'(ras_unf), 32'h1);
        ret = 1'b0; call = 1'b1; jimm = 26'h10; reset = 1'b1;
        cycle();
        chk("rst_call_pc", pc, 32'h0);
        chk("rst_call_empty", 32'(ras_empty), 32'h1);
        chk("rst_call_unf", 32'(ras_unf), 32'h0);
        chk("rst_call_ovf", 32'(ras_ovf), 32'h0);
        reset = 1'b0;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
